// File: rtl/glitch_alarm_controller.sv
// rtl/glitch_alarm_controller.sv - Sequencer and alarm qualifier for an array of TDL glitch detectors
module glitch_alarm_controller #(
  parameter int N_DET         = 4,
  parameter int WARMUP_CYCLES = 64,
  parameter int THRESH        = 2,
  parameter int WINDOW        = 256,
  parameter int CNT_W         = 16
) (
  input  logic               clk_ps,
  input  logic               rst_n,
  input  logic [N_DET-1:0]   alarm_in,
  input  logic [N_DET-1:0]   det_mask,
  input  logic               arm,
  input  logic               clear,
  output logic               tdl_en,
  output logic               armed,
  output logic               glitch_irq,
  output logic [N_DET-1:0]   trip_vec,
  output logic [CNT_W-1:0]   event_count,
  output logic [1:0]         state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WARMUP  = 2'd1;
  localparam logic [1:0] S_MONITOR = 2'd2;
  localparam logic [1:0] S_TRIPPED = 2'd3;

  localparam int WU_W  = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WU_W-1:0]  WU_LAST  = WU_W'(WARMUP_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  logic [1:0]       state_q;
  logic [N_DET-1:0] alarm_q;
  logic [WU_W-1:0]  warm_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic             win_active;
  logic [7:0]       hit_cnt;
  logic [7:0]       hit_cnt_nxt;
  logic             hit;
  logic             win_expire;
  logic             win_restart;
  logic             trip;

  assign hit         = |alarm_q;
  assign win_expire  = win_active && (win_cnt == WIN_LAST);
  // A hit on the expiry cycle opens a fresh window rather than extending the old one.
  assign win_restart = hit && (!win_active || win_expire);

  always_comb begin
    hit_cnt_nxt = hit_cnt;
    if (win_restart) begin
      hit_cnt_nxt = 8'd1;
    end else if (hit) begin
      if (hit_cnt != 8'hff) hit_cnt_nxt = hit_cnt + 8'd1;
    end else if (win_expire) begin
      hit_cnt_nxt = 8'd0;
    end
  end

  assign trip = hit && (hit_cnt_nxt >= 8'(THRESH));

  always_ff @(posedge clk_ps) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      alarm_q     <= '0;
      warm_cnt    <= '0;
      win_cnt     <= '0;
      win_active  <= 1'b0;
      hit_cnt     <= 8'd0;
      trip_vec    <= '0;
      event_count <= '0;
    end else begin
      alarm_q <= alarm_in & det_mask;
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_q  <= S_WARMUP;
            warm_cnt <= '0;
          end
        end
        S_WARMUP: begin
          if (!arm) begin
            state_q <= S_IDLE;
          end else if (warm_cnt == WU_LAST) begin
            state_q    <= S_MONITOR;
            hit_cnt    <= 8'd0;
            win_active <= 1'b0;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        S_MONITOR: begin
          hit_cnt <= hit_cnt_nxt;
          if (win_restart) begin
            win_cnt    <= '0;
            win_active <= 1'b1;
          end else if (win_expire) begin
            win_active <= 1'b0;
          end else if (win_active) begin
            win_cnt <= win_cnt + 1'b1;
          end
          // A trip wins over a simultaneous disarm so the event is never lost.
          if (trip) begin
            state_q  <= S_TRIPPED;
            trip_vec <= alarm_q;
            if (event_count != {CNT_W{1'b1}}) event_count <= event_count + 1'b1;
          end else if (!arm) begin
            state_q <= S_IDLE;
          end
        end
        S_TRIPPED: begin
          if (clear) begin
            state_q  <= S_IDLE;
            trip_vec <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign state      = state_q;
  assign tdl_en     = (state_q != S_IDLE);
  assign armed      = (state_q == S_MONITOR);
  assign glitch_irq = (state_q == S_TRIPPED);

endmodule

// File: tb/tb_glitch_alarm_controller.sv
// tb/tb_glitch_alarm_controller.sv - Self-checking bench for glitch_alarm_controller
module tb_glitch_alarm_controller;

  localparam int WU  = 64;
  localparam int TH  = 2;
  localparam int WIN = 256;
  localparam int CW  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, arm, clear;
  logic [3:0]  alarm_in, det_mask;
  logic        tdl_en, armed, glitch_irq;
  logic [3:0]  trip_vec;
  logic [15:0] event_count;
  logic [1:0]  state;

  logic        s_rst_n, s_arm, s_clear;
  logic [3:0]  s_alarm, s_mask;
  logic        s_tdl_en, s_armed, s_irq;
  logic [3:0]  s_trip_vec;
  logic [1:0]  s_count;
  logic [1:0]  s_state;

  glitch_alarm_controller #(.N_DET(4), .WARMUP_CYCLES(WU), .THRESH(TH), .WINDOW(WIN), .CNT_W(CW)) dut (
    .clk_ps(clk), .rst_n(rst_n), .alarm_in(alarm_in), .det_mask(det_mask), .arm(arm), .clear(clear),
    .tdl_en(tdl_en), .armed(armed), .glitch_irq(glitch_irq), .trip_vec(trip_vec),
    .event_count(event_count), .state(state));

  glitch_alarm_controller #(.N_DET(4), .WARMUP_CYCLES(2), .THRESH(1), .WINDOW(4), .CNT_W(2)) dut_sat (
    .clk_ps(clk), .rst_n(s_rst_n), .alarm_in(s_alarm), .det_mask(s_mask), .arm(s_arm), .clear(s_clear),
    .tdl_en(s_tdl_en), .armed(s_armed), .glitch_irq(s_irq), .trip_vec(s_trip_vec),
    .event_count(s_count), .state(s_state));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: absolute-time bookkeeping of warm-up start and window start.
  int         m_state = 0;
  longint     cyc = 0;
  longint     m_warm_start = 0;
  longint     m_win_start = 0;
  bit         m_win_on = 0;
  int         m_hits = 0;
  int         m_events = 0;
  logic [3:0] m_aq = '0;
  logic [3:0] m_tv = '0;

  task automatic model_step();
    bit hit;
    hit = |m_aq;
    if (!rst_n) begin
      m_state = 0; m_win_on = 0; m_hits = 0; m_events = 0; m_tv = '0; m_aq = '0;
    end else begin
      case (m_state)
        0: if (arm) begin m_state = 1; m_warm_start = cyc; end
        1: begin
          if (!arm) m_state = 0;
          else if (cyc - m_warm_start >= WU) begin m_state = 2; m_win_on = 0; m_hits = 0; end
        end
        2: begin
          if (m_win_on && (cyc - m_win_start >= WIN)) begin m_win_on = 0; m_hits = 0; end
          if (hit) begin
            if (!m_win_on) begin m_win_on = 1; m_win_start = cyc; m_hits = 1; end
            else m_hits = (m_hits < 255) ? m_hits + 1 : 255;
          end
          if (hit && m_hits >= TH) begin
            m_state = 3; m_tv = m_aq;
            if (m_events < (1 << CW) - 1) m_events++;
          end else if (!arm) m_state = 0;
        end
        default: if (clear) begin m_state = 0; m_tv = '0; end
      endcase
      m_aq = alarm_in & det_mask;
    end
    cyc++;
  endtask

  function automatic logic [24:0] model_vec();
    return {m_state != 0, m_state == 2, m_state == 3, m_tv, 16'(m_events), 2'(m_state)};
  endfunction

  function automatic logic [24:0] dut_vec();
    return {tdl_en, armed, glitch_irq, trip_vec, event_count, state};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse(input logic [3:0] a, input int gap);
    alarm_in = a;
    tick();
    alarm_in = 4'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic go_monitor();
    arm = 1'b1;
    for (int i = 0; i < 300 && state != 2'd2; i++) tick();
    n_checks++;
    if (state !== 2'd2) begin
      n_fail++;
      $display("FAIL go_monitor_timeout: state=%0d required 2", state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; arm = 1'b0; clear = 1'b0; alarm_in = '0; det_mask = 4'hf;
    s_rst_n = 1'b0; s_arm = 1'b0; s_clear = 1'b0; s_alarm = '0; s_mask = 4'hf;
    tick(); tick();
    n_checks++;
    if (dut_vec() !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", dut_vec());
    end
  endtask

  task automatic test_warmup();
    int wcnt;
    rst_n = 1'b1; s_rst_n = 1'b1; arm = 1'b1;
    tick();
    n_checks++;
    if (state !== 2'd1 || tdl_en !== 1'b1 || armed !== 1'b0) begin
      n_fail++;
      $display("FAIL warmup_entry: state=%0d tdl_en=%b armed=%b required 1/1/0", state, tdl_en, armed);
    end
    wcnt = 0;
    for (int i = 0; i < 200 && state == 2'd1; i++) begin wcnt++; tick(); end
    n_checks++;
    if (wcnt != WU) begin
      n_fail++;
      $display("FAIL warmup_length: got %0d cycles required %0d", wcnt, WU);
    end
    n_checks++;
    if (state !== 2'd2 || armed !== 1'b1 || tdl_en !== 1'b1) begin
      n_fail++;
      $display("FAIL monitor_entry: state=%0d armed=%b tdl_en=%b required 2/1/1", state, armed, tdl_en);
    end
  endtask

  task automatic test_warmup_alarm();
    arm = 1'b0;
    tick();
    n_checks++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("FAIL disarm_to_idle: state=%0d required 0", state);
    end
    arm = 1'b1;
    tick(); tick(); tick();
    alarm_in = 4'b0001;
    repeat (6) tick();
    alarm_in = 4'b0;
    go_monitor();
    repeat (20) tick();
    n_checks++;
    if (state !== 2'd2 || event_count !== 16'd0 || glitch_irq !== 1'b0 || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL warmup_alarm_ignored: got %h required %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_two_hits();
    pulse(4'b0010, 10);
    alarm_in = 4'b0010;
    tick();
    alarm_in = 4'b0;
    n_checks++;
    if (glitch_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_before_eval: irq=%b required 0", glitch_irq);
    end
    tick();
    n_checks++;
    if (glitch_irq !== 1'b1 || trip_vec !== 4'b0010 || event_count !== 16'd1 || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL two_hit_trip: got %h required irq=1 tv=2 cnt=1 model %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_clear();
    arm = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++;
    if (state !== 2'd0 || trip_vec !== 4'b0 || event_count !== 16'd1 || glitch_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_to_idle: got %h required state=0 tv=0 cnt=1", dut_vec());
    end
  endtask

  task automatic test_window();
    go_monitor();
    pulse(4'b0010, 300);
    pulse(4'b0010, 256);
    pulse(4'b0010, 100);
    n_checks++;
    if (state !== 2'd2 || glitch_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL window_expiry_no_trip: state=%0d irq=%b required 2/0", state, glitch_irq);
    end
    alarm_in = 4'b0010;
    tick();
    alarm_in = 4'b0;
    tick();
    n_checks++;
    if (glitch_irq !== 1'b1 || trip_vec !== 4'b0010 || event_count !== 16'd2 || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL window_restart_trip: got %h required irq=1 tv=2 cnt=2 model %h", dut_vec(), model_vec());
    end
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_mask();
    go_monitor();
    det_mask = 4'b1110;
    alarm_in = 4'b0001;
    repeat (50) tick();
    n_checks++;
    if (state !== 2'd2 || glitch_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL masked_no_trip: state=%0d irq=%b required 2/0", state, glitch_irq);
    end
    alarm_in = 4'b1001; tick();
    alarm_in = 4'b0001; repeat (4) tick();
    alarm_in = 4'b1001; tick();
    alarm_in = 4'b0001; tick();
    n_checks++;
    if (glitch_irq !== 1'b1 || trip_vec !== 4'b1000 || event_count !== 16'd3 || dut_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL mask_trip_vec: got %h required irq=1 tv=8 cnt=3 model %h", dut_vec(), model_vec());
    end
    alarm_in = 4'b0; det_mask = 4'hf;
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_arm_drop_trip();
    go_monitor();
    pulse(4'b0100, 5);
    alarm_in = 4'b0100;
    tick();
    alarm_in = 4'b0;
    arm = 1'b0;
    tick();
    n_checks++;
    if (state !== 2'd3 || event_count !== 16'd4 || trip_vec !== 4'b0100) begin
      n_fail++;
      $display("FAIL trip_beats_disarm: got %h required state=3 tv=4 cnt=4", dut_vec());
    end
    clear = 1'b1; tick(); clear = 1'b0; tick();
    n_checks++;
    if (state !== 2'd0 || tdl_en !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_clear_disarmed: state=%0d tdl_en=%b required 0/0", state, tdl_en);
    end
    go_monitor();
    arm = 1'b0;
    tick();
    n_checks++;
    if (state !== 2'd0 || event_count !== 16'd4) begin
      n_fail++;
      $display("FAIL disarm_no_trip: state=%0d cnt=%0d required 0/4", state, event_count);
    end
  endtask

  task automatic test_reset_mid();
    go_monitor();
    pulse(4'b0001, 3);
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (dut_vec() !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_mid_monitor: got %h required 0", dut_vec());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int rate;
    arm = 1'b1;
    rate = 40;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) rate = $urandom_range(20, 400);
      arm = ($urandom_range(0, 299) != 0) ? 1'b1 : ~arm;
      clear = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) == 0) det_mask = 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++) alarm_in[b] = ($urandom_range(0, rate - 1) == 0);
      tick();
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got %h required %h", i, dut_vec(), model_vec());
      end
    end
    alarm_in = '0; clear = 1'b0; det_mask = 4'hf;
  endtask

  task automatic test_saturation();
    s_rst_n = 1'b0; tick(); s_rst_n = 1'b1;
    s_arm = 1'b1;
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 20 && s_state != 2'd2; i++) tick();
      s_alarm = 4'b0001; tick();
      s_alarm = 4'b0;    tick();
      n_checks++;
      if (s_irq !== 1'b1 || s_count !== 2'((t + 1 > 3) ? 3 : t + 1)) begin
        n_fail++;
        $display("FAIL sat_trip_%0d: irq=%b cnt=%0d required 1/%0d", t, s_irq, s_count, (t + 1 > 3) ? 3 : t + 1);
      end
      s_clear = 1'b1; tick(); s_clear = 1'b0;
    end
    n_checks++;
    if (s_count !== 2'd3 || s_state !== 2'd0) begin
      n_fail++;
      $display("FAIL count_saturated: cnt=%0d state=%0d required 3/0", s_count, s_state);
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_warmup_alarm();
    test_two_hits();
    test_clear();
    test_window();
    test_mask();
    test_arm_drop_trip();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
